// File: rtl/isdu_ctrl_pkg.sv
// LC-3 sequencer shared types: FSM states, opcodes
// and datapath mux encodings.
package isdu_ctrl_pkg;

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32,
    S00, S01, S04, S05, S06,
    S07, S09, S12, S16, S21,
    S22, S23, S25, S27, P1, P2
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] PC_INC   = 2'b00;
  localparam logic [1:0] PC_BUS   = 2'b01;
  localparam logic [1:0] PC_ADDER = 2'b10;

  localparam logic [1:0] DR_IR = 2'b00;
  localparam logic [1:0] DR_R6 = 2'b01;
  localparam logic [1:0] DR_R7 = 2'b10;

  localparam logic [1:0] SR1_HI = 2'b00;
  localparam logic [1:0] SR1_LO = 2'b01;
  localparam logic [1:0] SR1_R6 = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_NOT   = 2'b10;
  localparam logic [1:0] ALU_PASSA = 2'b11;

  function automatic logic is_mem(state_t s);
    return (s == S33) || (s == S25) || (s == S16);
  endfunction

endpackage

// File: rtl/isdu_ctrl_if.sv
// Control bundle between the LC-3 sequencer and the
// datapath: IR fields in, loads/gates/selects/strobes out.
interface isdu_ctrl_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic LD_MAR, LD_MDR, LD_IR, LD_BEN;
  logic LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX;
  logic [1:0] DRMUX;
  logic [1:0] SR1MUX;
  logic       SR2MUX;
  logic       ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN,
    output LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, DRMUX, SR1MUX, SR2MUX,
    output ADDR1MUX, ADDR2MUX, ALUK,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN,
    input  LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, DRMUX, SR1MUX, SR2MUX,
    input  ADDR1MUX, ADDR2MUX, ALUK,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/isdu_ctrl_mem_wait_ctr.sv
// 3-bit SRAM wait-state counter; done once the count
// reaches MEM_WAIT, held at zero while cleared.
module mem_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [2:0] WAIT_MAX = 3'(MEM_WAIT);

  logic [2:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= 3'd0;
    end else if (clear) begin
      cnt <= 3'd0;
    end else if (enable) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign done = (cnt == WAIT_MAX);

endmodule

// File: rtl/isdu_ctrl.sv
// LC-3 instruction sequencer: Moore FSM owning every
// datapath load, bus gate, mux select and SRAM strobe.
module isdu_ctrl
  import isdu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic         Clk,
  input  logic         Reset_n,
  isdu_ctrl_if.master  bus
);

  state_t state;
  logic   mem_st;
  logic   wait_done;

  assign mem_st = is_mem(state);

  // Counter sits at zero outside memory states, so
  // every memory state is entered with a fresh count.
  mem_wait_ctr #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (!mem_st),
    .enable  (mem_st && !wait_done),
    .done    (wait_done)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= HALTED;
    end else begin
      unique case (state)
        HALTED: if (bus.Run) state <= S18;
        S18:    state <= S33;
        S33:    if (wait_done) state <= S35;
        S35:    state <= S32;
        S32: begin
          unique case (1'b1)
            bus.Opcode == OP_ADD: state <= S01;
            bus.Opcode == OP_AND: state <= S05;
            bus.Opcode == OP_NOT: state <= S09;
            bus.Opcode == OP_BR:  state <= S00;
            bus.Opcode == OP_JMP: state <= S12;
            bus.Opcode == OP_JSR: state <= S04;
            bus.Opcode == OP_LDR: state <= S06;
            bus.Opcode == OP_STR: state <= S07;
            bus.Opcode == OP_PSE: state <= P1;
            default:              state <= S18;
          endcase
        end
        S00:    state <= bus.BEN ? S22 : S18;
        S04:    state <= S21;
        S06:    state <= S25;
        S25:    if (wait_done) state <= S27;
        S07:    state <= S23;
        S23:    state <= S16;
        S16:    if (wait_done) state <= S18;
        P1:     if (bus.Continue) state <= P2;
        P2:     if (!bus.Continue) state <= S18;
        default: state <= S18;
      endcase
    end
  end

  always_comb begin
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.LD_LED     = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.PCMUX      = PC_INC;
    bus.DRMUX      = DR_IR;
    bus.SR1MUX     = SR1_HI;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.ADDR2MUX   = A2_ZERO;
    bus.ALUK       = ALU_ADD;
    bus.Mem_CE     = !mem_st;
    bus.Mem_UB     = !mem_st;
    bus.Mem_LB     = !mem_st;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;
    unique case (state)
      S18: begin
        bus.LD_MAR = 1'b1;
        bus.LD_PC  = 1'b1;
        bus.GatePC = 1'b1;
      end
      S33, S25: begin
        bus.Mem_OE = 1'b0;
        bus.LD_MDR = wait_done;
      end
      S35: begin
        bus.LD_IR   = 1'b1;
        bus.GateMDR = 1'b1;
      end
      S32: bus.LD_BEN = 1'b1;
      S01, S05, S09: begin
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        bus.SR1MUX  = SR1_LO;
        bus.GateALU = 1'b1;
        bus.SR2MUX  = (state != S09) && bus.IR_5;
        bus.ALUK    = (state == S01) ? ALU_ADD :
                      (state == S05) ? ALU_AND : ALU_NOT;
      end
      S22: begin
        bus.LD_PC    = 1'b1;
        bus.PCMUX    = PC_ADDER;
        bus.ADDR2MUX = A2_OFF9;
      end
      S12: begin
        bus.LD_PC    = 1'b1;
        bus.PCMUX    = PC_ADDER;
        bus.SR1MUX   = SR1_LO;
        bus.ADDR1MUX = 1'b1;
      end
      S04: begin
        bus.LD_REG = 1'b1;
        bus.DRMUX  = DR_R7;
        bus.GatePC = 1'b1;
      end
      S21: begin
        bus.LD_PC    = 1'b1;
        bus.PCMUX    = PC_ADDER;
        bus.SR1MUX   = SR1_LO;
        bus.ADDR1MUX = !bus.IR_11;
        bus.ADDR2MUX = bus.IR_11 ? A2_OFF11 : A2_ZERO;
      end
      S06, S07: begin
        bus.LD_MAR     = 1'b1;
        bus.GateMARMUX = 1'b1;
        bus.SR1MUX     = SR1_LO;
        bus.ADDR1MUX   = 1'b1;
        bus.ADDR2MUX   = A2_OFF6;
      end
      S27: begin
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        bus.GateMDR = 1'b1;
      end
      S23: begin
        bus.LD_MDR  = 1'b1;
        bus.GateALU = 1'b1;
        bus.ALUK    = ALU_PASSA;
      end
      S16: bus.Mem_WE = 1'b0;
      P1:  bus.LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu_ctrl.sv
// Directed bench for the LC-3 sequencer: one DUT with
// MEM_WAIT=2 and one with MEM_WAIT=0 on shared inputs.
module tb_isdu_ctrl;
  import isdu_ctrl_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       run = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] opcode = 4'b0000;
  logic       ir5 = 1'b0;
  logic       ir11 = 1'b0;
  logic       ben = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 Clk = ~Clk;

  isdu_ctrl_if bif ();
  isdu_ctrl_if bif0 ();

  assign bif.Run       = run;
  assign bif.Continue  = cont;
  assign bif.Opcode    = opcode;
  assign bif.IR_5      = ir5;
  assign bif.IR_11     = ir11;
  assign bif.BEN       = ben;
  assign bif0.Run      = run;
  assign bif0.Continue = cont;
  assign bif0.Opcode   = opcode;
  assign bif0.IR_5     = ir5;
  assign bif0.IR_11    = ir11;
  assign bif0.BEN      = ben;

  isdu_ctrl #(.MEM_WAIT(2)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bif)
  );

  isdu_ctrl #(.MEM_WAIT(0)) dut0 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bif0)
  );

  wire [7:0] lds = {bif.LD_MAR, bif.LD_MDR, bif.LD_IR,
                    bif.LD_BEN, bif.LD_CC, bif.LD_REG,
                    bif.LD_PC, bif.LD_LED};
  wire [3:0] gates = {bif.GatePC, bif.GateMDR,
                      bif.GateALU, bif.GateMARMUX};
  wire [4:0] mem = {bif.Mem_CE, bif.Mem_UB, bif.Mem_LB,
                    bif.Mem_OE, bif.Mem_WE};
  wire [4:0] mem0 = {bif0.Mem_CE, bif0.Mem_UB,
                     bif0.Mem_LB, bif0.Mem_OE,
                     bif0.Mem_WE};

  task automatic step;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset;
    @(negedge Clk);
    Reset_n = 1'b0;
    run = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic start_insn(input logic [3:0] op);
    do_reset();
    opcode = op;
    run = 1'b1;
    step();
    run = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (dut.state !== HALTED || lds !== 8'h00 ||
        gates !== 4'h0 || mem !== 5'b11111) begin
      errors++;
      $display("FAIL reset_idle st=%0d ld=%h g=%h m=%b",
               dut.state, lds, gates, mem);
    end
    checks++;
    if ({bif.PCMUX, bif.DRMUX, bif.SR1MUX, bif.SR2MUX,
         bif.ADDR1MUX, bif.ADDR2MUX, bif.ALUK}
        !== 12'h000) begin
      errors++;
      $display("FAIL reset_mux got nonzero select, want 0");
    end
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    checks++;
    if (dut.state !== S33 || bif.Mem_OE !== 1'b0) begin
      errors++;
      $display("FAIL reset_pre st=%0d oe=%b want %0d 0",
               dut.state, bif.Mem_OE, S33);
    end
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if (dut.state !== HALTED || bif.Mem_OE !== 1'b1 ||
        lds !== 8'h00 || mem !== 5'b11111) begin
      errors++;
      $display("FAIL reset_async st=%0d oe=%b ld=%h",
               dut.state, bif.Mem_OE, lds);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_fetch;
    do_reset();
    opcode = 4'b1000;
    run = 1'b1;
    step();
    run = 1'b0;
    checks++;
    if (dut.state !== S18 || lds !== 8'b1000_0010 ||
        gates !== 4'b1000 || bif.PCMUX !== 2'b00) begin
      errors++;
      $display("FAIL fetch_s18 st=%0d ld=%b g=%b",
               dut.state, lds, gates);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut.state !== S33 || bif.LD_MDR !== (i == 2) ||
          mem !== 5'b00001) begin
        errors++;
        $display("FAIL fetch_s33_%0d st=%0d mdr=%b m=%b",
                 i, dut.state, bif.LD_MDR, mem);
      end
    end
    step();
    checks++;
    if (dut.state !== S35 || lds !== 8'b0010_0000 ||
        gates !== 4'b0100 || mem !== 5'b11111) begin
      errors++;
      $display("FAIL fetch_s35 st=%0d ld=%b g=%b",
               dut.state, lds, gates);
    end
    step();
    checks++;
    if (dut.state !== S32 || lds !== 8'b0001_0000) begin
      errors++;
      $display("FAIL fetch_s32 st=%0d ld=%b",
               dut.state, lds);
    end
    step();
    checks++;
    if (dut.state !== S18) begin
      errors++;
      $display("FAIL fetch_unimpl st=%0d want %0d",
               dut.state, S18);
    end
  endtask

  task automatic test_add;
    ir5 = 1'b1;
    ir11 = 1'b0;
    start_insn(4'b0001);
    step();
    checks++;
    if (dut.state !== S01 || lds !== 8'b0000_1100 ||
        gates !== 4'b0010 ||
        {bif.DRMUX, bif.SR1MUX, bif.SR2MUX, bif.ALUK}
        !== 7'b00_01_1_00) begin
      errors++;
      $display("FAIL add_s01 st=%0d ld=%b g=%b",
               dut.state, lds, gates);
    end
    step();
    checks++;
    if (dut.state !== S18) begin
      errors++;
      $display("FAIL add_next st=%0d want %0d",
               dut.state, S18);
    end
  endtask

  task automatic test_br;
    ben = 1'b0;
    start_insn(4'b0000);
    step();
    checks++;
    if (dut.state !== S00 || bif.LD_PC !== 1'b0) begin
      errors++;
      $display("FAIL br_nt_s00 st=%0d pc=%b",
               dut.state, bif.LD_PC);
    end
    step();
    checks++;
    if (dut.state !== S18) begin
      errors++;
      $display("FAIL br_nt_next st=%0d want %0d",
               dut.state, S18);
    end
    ben = 1'b1;
    start_insn(4'b0000);
    step();
    step();
    checks++;
    if (dut.state !== S22 || lds !== 8'b0000_0010 ||
        {bif.PCMUX, bif.ADDR1MUX, bif.ADDR2MUX}
        !== 5'b10_0_10) begin
      errors++;
      $display("FAIL br_t_s22 st=%0d ld=%b pcm=%b a2=%b",
               dut.state, lds, bif.PCMUX, bif.ADDR2MUX);
    end
    step();
    checks++;
    if (dut.state !== S18) begin
      errors++;
      $display("FAIL br_t_next st=%0d want %0d",
               dut.state, S18);
    end
    ben = 1'b0;
  endtask

  task automatic test_jsr;
    ir11 = 1'b1;
    start_insn(4'b0100);
    step();
    checks++;
    if (dut.state !== S04 || lds !== 8'b0000_0100 ||
        gates !== 4'b1000 || bif.DRMUX !== 2'b10) begin
      errors++;
      $display("FAIL jsr_s04 st=%0d ld=%b dr=%b",
               dut.state, lds, bif.DRMUX);
    end
    step();
    checks++;
    if (dut.state !== S21 || lds !== 8'b0000_0010 ||
        {bif.PCMUX, bif.ADDR1MUX, bif.ADDR2MUX}
        !== 5'b10_0_11) begin
      errors++;
      $display("FAIL jsr_s21 st=%0d a1=%b a2=%b",
               dut.state, bif.ADDR1MUX, bif.ADDR2MUX);
    end
    ir11 = 1'b0;
  endtask

  task automatic test_ldr;
    start_insn(4'b0110);
    step();
    checks++;
    if (dut.state !== S06 || lds !== 8'b1000_0000 ||
        gates !== 4'b0001 ||
        {bif.ADDR1MUX, bif.ADDR2MUX} !== 3'b1_01) begin
      errors++;
      $display("FAIL ldr_s06 st=%0d ld=%b g=%b",
               dut.state, lds, gates);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut.state !== S25 || bif.LD_MDR !== (i == 2) ||
          mem !== 5'b00001) begin
        errors++;
        $display("FAIL ldr_s25_%0d st=%0d mdr=%b m=%b",
                 i, dut.state, bif.LD_MDR, mem);
      end
    end
    step();
    checks++;
    if (dut.state !== S27 || lds !== 8'b0000_1100 ||
        gates !== 4'b0100) begin
      errors++;
      $display("FAIL ldr_s27 st=%0d ld=%b g=%b",
               dut.state, lds, gates);
    end
  endtask

  task automatic test_str_nowait;
    do_reset();
    opcode = 4'b0111;
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    checks++;
    if (dut0.state !== S33 || bif0.LD_MDR !== 1'b1) begin
      errors++;
      $display("FAIL str_s33 st=%0d mdr=%b want %0d 1",
               dut0.state, bif0.LD_MDR, S33);
    end
    repeat (3) step();
    checks++;
    if (dut0.state !== S07 || mem0 !== 5'b11111) begin
      errors++;
      $display("FAIL str_s07 st=%0d m=%b",
               dut0.state, mem0);
    end
    step();
    checks++;
    if (dut0.state !== S23 || mem0 !== 5'b11111 ||
        bif0.LD_MDR !== 1'b1 || bif0.ALUK !== 2'b11) begin
      errors++;
      $display("FAIL str_s23 st=%0d m=%b aluk=%b",
               dut0.state, mem0, bif0.ALUK);
    end
    step();
    checks++;
    if (dut0.state !== S16 || mem0 !== 5'b00010) begin
      errors++;
      $display("FAIL str_s16 st=%0d m=%b want 00010",
               dut0.state, mem0);
    end
    step();
    checks++;
    if (dut0.state !== S18 || mem0 !== 5'b11111) begin
      errors++;
      $display("FAIL str_next st=%0d m=%b",
               dut0.state, mem0);
    end
  endtask

  task automatic test_pause;
    cont = 1'b1;
    start_insn(4'b1101);
    step();
    checks++;
    if (dut.state !== P1 || lds !== 8'b0000_0001) begin
      errors++;
      $display("FAIL pause_p1 st=%0d ld=%b",
               dut.state, lds);
    end
    step();
    step();
    checks++;
    if (dut.state !== P2 || bif.LD_LED !== 1'b0) begin
      errors++;
      $display("FAIL pause_hold st=%0d led=%b",
               dut.state, bif.LD_LED);
    end
    cont = 1'b0;
    step();
    checks++;
    if (dut.state !== S18) begin
      errors++;
      $display("FAIL pause_rel st=%0d want %0d",
               dut.state, S18);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_add();
    test_br();
    test_jsr();
    test_ldr();
    test_str_nowait();
    test_pause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
